// File: rtl/histogram_peak_finder.sv
// Reads x/y projection histograms from histogramTop, extracts per-axis peak and
// thresholded extent, clears the histogram block and publishes registered results.
module histogram_peak_finder #(
  parameter int X_BINS         = 240,
  parameter int Y_BINS         = 180,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] threshold,
  output logic              readHistogram,
  output logic              clearHistogram,
  input  logic [DATA_W-1:0] xHistogramIn,
  input  logic              xValid,
  input  logic [DATA_W-1:0] yHistogramIn,
  input  logic              yValid,
  input  logic              histogramCleared,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              objectFound,
  output logic [7:0]        xPeakIndex,
  output logic [7:0]        yPeakIndex,
  output logic [DATA_W-1:0] xPeakValue,
  output logic [DATA_W-1:0] yPeakValue,
  output logic [7:0]        xMin,
  output logic [7:0]        xMax,
  output logic [7:0]        yMin,
  output logic [7:0]        yMax
);

  localparam int XCW = $clog2(X_BINS + 1);
  localparam int YCW = $clog2(Y_BINS + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_read;
  logic              r_clear;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [TW-1:0]     r_idle;

  logic [XCW-1:0]    r_x_cnt;
  logic [DATA_W-1:0] r_x_pk_val;
  logic [7:0]        r_x_pk_idx;
  logic              r_x_found;
  logic [7:0]        r_x_min;
  logic [7:0]        r_x_max;

  logic [YCW-1:0]    r_y_cnt;
  logic [DATA_W-1:0] r_y_pk_val;
  logic [7:0]        r_y_pk_idx;
  logic              r_y_found;
  logic [7:0]        r_y_min;
  logic [7:0]        r_y_max;

  logic              r_obj;
  logic [7:0]        r_pub_x_idx;
  logic [7:0]        r_pub_y_idx;
  logic [DATA_W-1:0] r_pub_x_val;
  logic [DATA_W-1:0] r_pub_y_val;
  logic [7:0]        r_pub_x_min;
  logic [7:0]        r_pub_x_max;
  logic [7:0]        r_pub_y_min;
  logic [7:0]        r_pub_y_max;

  logic              w_x_take;
  logic              w_y_take;
  logic              w_x_full;
  logic              w_y_full;
  logic [7:0]        w_x_idx;
  logic [7:0]        w_y_idx;
  logic              w_beat;
  logic              w_timeout;

  // Beats past the last bin are not taken, so the counters saturate at the bin count.
  assign w_x_take  = xValid && (r_x_cnt < XCW'(X_BINS));
  assign w_y_take  = yValid && (r_y_cnt < YCW'(Y_BINS));
  assign w_x_full  = (r_x_cnt == XCW'(X_BINS)) || (w_x_take && (r_x_cnt == XCW'(X_BINS - 1)));
  assign w_y_full  = (r_y_cnt == YCW'(Y_BINS)) || (w_y_take && (r_y_cnt == YCW'(Y_BINS - 1)));
  assign w_x_idx   = 8'(r_x_cnt);
  assign w_y_idx   = 8'(r_y_cnt);
  assign w_beat    = xValid || yValid;
  assign w_timeout = !w_beat && (r_idle == TW'(TIMEOUT_CYCLES - 1));

  // Control FSM, per-axis trackers and published result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_read      <= 1'b0;
      r_clear     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_idle      <= '0;
      r_x_cnt     <= '0;
      r_x_pk_val  <= '0;
      r_x_pk_idx  <= 8'd0;
      r_x_found   <= 1'b0;
      r_x_min     <= 8'd0;
      r_x_max     <= 8'd0;
      r_y_cnt     <= '0;
      r_y_pk_val  <= '0;
      r_y_pk_idx  <= 8'd0;
      r_y_found   <= 1'b0;
      r_y_min     <= 8'd0;
      r_y_max     <= 8'd0;
      r_obj       <= 1'b0;
      r_pub_x_idx <= 8'd0;
      r_pub_y_idx <= 8'd0;
      r_pub_x_val <= '0;
      r_pub_y_val <= '0;
      r_pub_x_min <= 8'd0;
      r_pub_x_max <= 8'd0;
      r_pub_y_min <= 8'd0;
      r_pub_y_max <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= S_READ;
            r_read     <= 1'b1;
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_idle     <= '0;
            r_x_cnt    <= '0;
            r_x_pk_val <= '0;
            r_x_pk_idx <= 8'd0;
            r_x_found  <= 1'b0;
            r_x_min    <= 8'd0;
            r_x_max    <= 8'd0;
            r_y_cnt    <= '0;
            r_y_pk_val <= '0;
            r_y_pk_idx <= 8'd0;
            r_y_found  <= 1'b0;
            r_y_min    <= 8'd0;
            r_y_max    <= 8'd0;
          end
        end

        S_READ: begin
          if (w_x_take) begin
            r_x_cnt <= r_x_cnt + XCW'(1);
            // Strict compare keeps the lowest index on ties.
            if (xHistogramIn > r_x_pk_val) begin
              r_x_pk_val <= xHistogramIn;
              r_x_pk_idx <= w_x_idx;
            end
            if (xHistogramIn >= threshold) begin
              if (!r_x_found) begin
                r_x_found <= 1'b1;
                r_x_min   <= w_x_idx;
              end
              r_x_max <= w_x_idx;
            end
          end
          if (w_y_take) begin
            r_y_cnt <= r_y_cnt + YCW'(1);
            if (yHistogramIn > r_y_pk_val) begin
              r_y_pk_val <= yHistogramIn;
              r_y_pk_idx <= w_y_idx;
            end
            if (yHistogramIn >= threshold) begin
              if (!r_y_found) begin
                r_y_found <= 1'b1;
                r_y_min   <= w_y_idx;
              end
              r_y_max <= w_y_idx;
            end
          end

          // Any strobe, even an excess one, proves the source is alive.
          r_idle <= w_beat ? '0 : r_idle + TW'(1);

          if ((w_x_full && w_y_full) || w_timeout) begin
            r_state <= S_CLEAR;
            r_read  <= 1'b0;
            r_clear <= 1'b1;
            r_idle  <= '0;
            if (w_timeout) begin
              r_error <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          if (histogramCleared) begin
            r_state <= S_DONE;
            r_clear <= 1'b0;
            r_done  <= 1'b1;
            // An aborted read leaves the previous results published.
            if (!r_error) begin
              r_pub_x_idx <= r_x_pk_idx;
              r_pub_y_idx <= r_y_pk_idx;
              r_pub_x_val <= r_x_pk_val;
              r_pub_y_val <= r_y_pk_val;
              if (r_x_found && r_y_found) begin
                r_obj       <= 1'b1;
                r_pub_x_min <= r_x_min;
                r_pub_x_max <= r_x_max;
                r_pub_y_min <= r_y_min;
                r_pub_y_max <= r_y_max;
              end else begin
                r_obj       <= 1'b0;
                r_pub_x_min <= 8'd0;
                r_pub_x_max <= 8'd0;
                r_pub_y_min <= 8'd0;
                r_pub_y_max <= 8'd0;
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
          r_clear <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign readHistogram  = r_read;
  assign clearHistogram = r_clear;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign objectFound    = r_obj;
  assign xPeakIndex     = r_pub_x_idx;
  assign yPeakIndex     = r_pub_y_idx;
  assign xPeakValue     = r_pub_x_val;
  assign yPeakValue     = r_pub_y_val;
  assign xMin           = r_pub_x_min;
  assign xMax           = r_pub_x_max;
  assign yMin           = r_pub_y_min;
  assign yMax           = r_pub_y_max;

endmodule

// File: tb/tb_histogram_peak_finder.sv
// Self-checking bench for histogram_peak_finder: acts as histogramTop, streams
// histograms and compares published results with an array-based reference.
module tb_histogram_peak_finder;

  localparam int XB = 240;
  localparam int YB = 180;
  localparam int TO = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] threshold;
  logic       readHistogram;
  logic       clearHistogram;
  logic [7:0] xHistogramIn;
  logic       xValid;
  logic [7:0] yHistogramIn;
  logic       yValid;
  logic       histogramCleared;
  logic       busy;
  logic       done;
  logic       error;
  logic       objectFound;
  logic [7:0] xPeakIndex;
  logic [7:0] yPeakIndex;
  logic [7:0] xPeakValue;
  logic [7:0] yPeakValue;
  logic [7:0] xMin;
  logic [7:0] xMax;
  logic [7:0] yMin;
  logic [7:0] yMax;

  int n_checks = 0;
  int n_fail   = 0;

  int xh[XB];
  int yh[YB];

  logic [64:0] got_res;
  logic [64:0] exp_res;
  logic [64:0] prev_res;
  int   done_cnt, overlap, clr_hi, idle_run, idle_at_clear;
  int   done_step, last_clr_step;
  logic got_err, err_after_start, post_busy, post_err, budget_hit;

  always #5 clk = ~clk;

  histogram_peak_finder #(
    .X_BINS(XB), .Y_BINS(YB), .DATA_W(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .threshold(threshold),
    .readHistogram(readHistogram), .clearHistogram(clearHistogram),
    .xHistogramIn(xHistogramIn), .xValid(xValid),
    .yHistogramIn(yHistogramIn), .yValid(yValid),
    .histogramCleared(histogramCleared),
    .busy(busy), .done(done), .error(error), .objectFound(objectFound),
    .xPeakIndex(xPeakIndex), .yPeakIndex(yPeakIndex),
    .xPeakValue(xPeakValue), .yPeakValue(yPeakValue),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax)
  );

  function automatic logic [64:0] model(input int thr);
    int xpi = 0, xpv = 0, xmn = -1, xmx = 0;
    int ypi = 0, ypv = 0, ymn = -1, ymx = 0;
    bit of;
    for (int i = 0; i < XB; i++) begin
      if (xh[i] > xpv) begin xpv = xh[i]; xpi = i; end
      if (xh[i] >= thr) begin if (xmn < 0) xmn = i; xmx = i; end
    end
    for (int i = 0; i < YB; i++) begin
      if (yh[i] > ypv) begin ypv = yh[i]; ypi = i; end
      if (yh[i] >= thr) begin if (ymn < 0) ymn = i; ymx = i; end
    end
    of = (xmn >= 0) && (ymn >= 0);
    if (!of) begin xmn = 0; xmx = 0; ymn = 0; ymx = 0; end
    return {of, 8'(xpi), 8'(xpv), 8'(xmn), 8'(xmx), 8'(ypi), 8'(ypv), 8'(ymn), 8'(ymx)};
  endfunction

  function automatic logic [64:0] dut_res();
    return {objectFound, xPeakIndex, xPeakValue, xMin, xMax, yPeakIndex, yPeakValue, yMin, yMax};
  endfunction

  function automatic logic [69:0] dut_all();
    return {readHistogram, clearHistogram, busy, done, error, objectFound,
            xPeakIndex, yPeakIndex, xPeakValue, yPeakValue, xMin, xMax, yMin, yMax};
  endfunction

  task automatic fill_random(input int maxv, input bit y_empty, input int thr);
    for (int i = 0; i < XB; i++)
      xh[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, maxv) : $urandom_range(0, 15);
    for (int i = 0; i < YB; i++)
      if (y_empty) yh[i] = $urandom_range(0, thr - 1);
      else yh[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, maxv) : $urandom_range(0, 15);
  endtask

  // Plays histogramTop for one start..done transaction and records observations.
  task automatic run_stream(input int y_period, input int x_extra, input int y_stop,
                            input int clr_delay, input bit start_in_clear);
    int xi = 0, yi = 0, cyc = 0, clr_cnt = 0;
    bit clr_seen = 0;
    done_cnt = 0; overlap = 0; clr_hi = 0; idle_run = 0; idle_at_clear = -1;
    done_step = -1; last_clr_step = -1; budget_hit = 1'b1;
    histogramCleared = (clr_delay == 0);
    for (int step = 0; step < 6000; step++) begin
      @(negedge clk);
      start = (step == 0) ? 1'b1 : 1'b0;
      if (step == 1) err_after_start = error;
      if (clearHistogram) begin
        clr_seen = 1;
        clr_hi++;
        clr_cnt++;
        last_clr_step = step;
        if (idle_at_clear < 0) idle_at_clear = idle_run;
        if (start_in_clear && clr_cnt == 2) start = 1'b1;
      end
      if (clr_seen && readHistogram) overlap++;
      if (clr_delay > 0) histogramCleared = clearHistogram && (clr_cnt >= clr_delay);
      if (done) begin
        done_cnt++;
        done_step = step;
        got_res = dut_res();
        got_err = error;
      end else if (done_cnt > 0) begin
        post_busy = busy;
        post_err = error;
        budget_hit = 1'b0;
        break;
      end
      xValid = 1'b0;
      yValid = 1'b0;
      if (readHistogram) begin
        if (xi < XB + x_extra) begin
          xValid = 1'b1;
          xHistogramIn = (xi < XB) ? 8'(xh[xi]) : 8'd255;
          xi++;
        end
        if ((cyc % y_period) == 0 && yi < y_stop) begin
          yValid = 1'b1;
          yHistogramIn = 8'(yh[yi]);
          yi++;
        end
        cyc++;
        if (!xValid && !yValid) idle_run++;
        else idle_run = 0;
      end
    end
    start = 1'b0;
    xValid = 1'b0;
    yValid = 1'b0;
    n_checks++;
    if (budget_hit) begin
      n_fail++;
      $display("FAIL stream_budget: done never completed within cycle budget");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut_all() !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", dut_all());
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_all() !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0", dut_all());
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < XB; i++) xh[i] = (i >= 50 && i <= 60) ? 20 : 0;
    xh[55] = 200;
    for (int i = 0; i < YB; i++) yh[i] = (i >= 30 && i <= 40) ? 15 : 0;
    yh[33] = 90;
    threshold = 8'd10;
    run_stream(1, 0, YB, 0, 1'b0);
    exp_res = {1'b1, 8'd55, 8'd200, 8'd50, 8'd60, 8'd33, 8'd90, 8'd30, 8'd40};
    n_checks++;
    if (got_res !== exp_res) begin
      n_fail++; $display("FAIL basic_result: got %h expected %h", got_res, exp_res);
    end
    n_checks++;
    if (done_cnt !== 1 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: width %0d err %0b expected 1 0", done_cnt, got_err);
    end
    n_checks++;
    if (clr_hi !== 1 || overlap !== 0 || post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_clear: clr %0d overlap %0d busy %0b expected 1 0 0", clr_hi, overlap, post_busy);
    end
    prev_res = exp_res;
  endtask

  task automatic test_tie_empty();
    for (int i = 0; i < XB; i++) xh[i] = 0;
    for (int i = 0; i < YB; i++) yh[i] = 0;
    xh[10] = 77;
    xh[20] = 77;
    threshold = 8'd5;
    run_stream(1, 0, YB, 0, 1'b0);
    exp_res = {1'b0, 8'd10, 8'd77, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    n_checks++;
    if (got_res !== exp_res) begin
      n_fail++; $display("FAIL tie_empty_result: got %h expected %h", got_res, exp_res);
    end
    prev_res = exp_res;
  endtask

  task automatic test_interleave();
    threshold = 8'($urandom_range(20, 120));
    fill_random(200, 1'b0, 0);
    run_stream(3, 5, YB, 0, 1'b0);
    exp_res = model(int'(threshold));
    n_checks++;
    if (got_res !== exp_res) begin
      n_fail++; $display("FAIL interleave_result: got %h expected %h", got_res, exp_res);
    end
    n_checks++;
    if (overlap !== 0 || done_cnt !== 1 || clr_hi !== 1) begin
      n_fail++;
      $display("FAIL interleave_ctrl: overlap %0d done %0d clr %0d expected 0 1 1", overlap, done_cnt, clr_hi);
    end
    prev_res = exp_res;
  endtask

  task automatic test_timeout();
    threshold = 8'd1;
    fill_random(255, 1'b0, 0);
    run_stream(1, 0, 100, 0, 1'b0);
    n_checks++;
    if (got_err !== 1'b1 || post_err !== 1'b1 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL timeout_flag: err %0b sticky %0b done %0d expected 1 1 1", got_err, post_err, done_cnt);
    end
    n_checks++;
    if (idle_at_clear !== TO || clr_hi < 1) begin
      n_fail++; $display("FAIL timeout_idle: idle %0d clr %0d expected %0d >=1", idle_at_clear, clr_hi, TO);
    end
    n_checks++;
    if (got_res !== prev_res) begin
      n_fail++; $display("FAIL timeout_hold: got %h expected %h", got_res, prev_res);
    end
  endtask

  task automatic test_clear_handshake();
    threshold = 8'($urandom_range(20, 120));
    fill_random(255, 1'b0, 0);
    run_stream(1, 0, YB, 7, 1'b1);
    exp_res = model(int'(threshold));
    n_checks++;
    if (err_after_start !== 1'b0 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL clear_err_cleared: got %0b %0b expected 0 0", err_after_start, got_err);
    end
    n_checks++;
    if (clr_hi !== 7 || done_step !== last_clr_step + 1) begin
      n_fail++;
      $display("FAIL clear_handshake: clr %0d done_step %0d last_clr %0d expected 7 and +1", clr_hi, done_step, last_clr_step);
    end
    n_checks++;
    if (got_res !== exp_res || post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_result: got %h busy %0b expected %h 0", got_res, post_busy, exp_res);
    end
    prev_res = exp_res;
  endtask

  task automatic test_reset_mid_read();
    int sent = 0;
    threshold = 8'd40;
    fill_random(255, 1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400 && sent < 120; k++) begin
      xValid = readHistogram;
      yValid = readHistogram;
      xHistogramIn = 8'(xh[sent]);
      yHistogramIn = 8'(yh[sent]);
      if (readHistogram) sent++;
      @(negedge clk);
    end
    xValid = 1'b0;
    yValid = 1'b0;
    n_checks++;
    if (readHistogram !== 1'b1) begin
      n_fail++; $display("FAIL midreset_precond: readHistogram %0b expected 1", readHistogram);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut_all() !== 70'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0", dut_all());
    end
    @(negedge clk);
    reset = 1'b0;
    run_stream(1, 0, YB, 0, 1'b0);
    exp_res = model(40);
    n_checks++;
    if (got_res !== exp_res || got_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_rerun: got %h err %0b expected %h 0", got_res, got_err, exp_res);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      threshold = 8'($urandom_range(16, 200));
      fill_random(255, (r == 2), int'(threshold));
      run_stream(1 + (r % 2), 0, YB, r, 1'b0);
      exp_res = model(int'(threshold));
      n_checks++;
      if (got_res !== exp_res || done_cnt !== 1) begin
        n_fail++;
        $display("FAIL random_%0d: got %h done %0d expected %h 1", r, got_res, done_cnt, exp_res);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    threshold = 8'd0;
    xHistogramIn = 8'd0;
    xValid = 1'b0;
    yHistogramIn = 8'd0;
    yValid = 1'b0;
    histogramCleared = 1'b0;
    got_res = '0;
    exp_res = '0;
    prev_res = '0;
    got_err = 1'b0;
    err_after_start = 1'b0;
    post_busy = 1'b0;
    post_err = 1'b0;
    test_reset();
    test_basic();
    test_tie_empty();
    test_interleave();
    test_timeout();
    test_clear_handshake();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/histogram_peak_finder.md
Name: histogram_peak_finder

Overview:
- Sits directly downstream of histogramTop. Once filtering completes, it drives readHistogram and consumes the streamed x (column) and y (row) projection histograms.
- Per axis it extracts the peak bin (index and value) and the thresholded extent, which forms the object bounding box.
- It then issues clearHistogram, waits for histogramCleared, and pulses done with registered results for the tracking logic.

Parameters:
- X_BINS, 240, number of x histogram bins (image width)
- Y_BINS, 180, number of y histogram bins (image height)
- DATA_W, 8, histogram bin value width
- TIMEOUT_CYCLES, 1024, idle cycles in READ with no valid beat before error abort

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a histogram read; sample when filterDone is seen
- threshold  in  DATA_W  minimum bin value counted as object
- readHistogram  out  1  to histogramTop: stream histograms
- clearHistogram  out  1  to histogramTop: clear bins
- xHistogramIn  in  DATA_W  x bin value (from xHistogramOut)
- xValid  in  1  x bin beat strobe
- yHistogramIn  in  DATA_W  y bin value (from yHistogramOut)
- yValid  in  1  y bin beat strobe
- histogramCleared  in  1  clear complete (level or pulse)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle result-valid pulse
- error  out  1  timeout abort flag, sticky until next accepted start
- objectFound  out  1  both axes had at least one bin >= threshold
- xPeakIndex, yPeakIndex  out  8  bin index of maximum value
- xPeakValue, yPeakValue  out  DATA_W  maximum bin value
- xMin, xMax, yMin, yMax  out  8  first and last bin index with value >= threshold

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; internal counters and trackers 0.
- States and transitions: IDLE -> READ -> CLEAR -> DONE -> IDLE.
- IDLE:
  - start=1: load working registers (peak value 0, peak index 0, min/max invalid, bin counters 0), clear error, go to READ next cycle.
  - xValid/yValid beats in IDLE are ignored.
- READ:
  - readHistogram=1 throughout.
  - Each xValid beat is bin xCnt; each yValid beat is bin yCnt. The axes are counted independently and may arrive in the same cycle.
  - Peak update: value > current peak (strict), so the lowest index wins ties. An all-zero histogram gives peak value 0, index 0.
  - Extent: on the first bin >= threshold, set min=max=index. On later qualifying bins, max=index.
  - Beats beyond X_BINS or Y_BINS are ignored. Counters saturate and do not wrap.
  - Exit: once xCnt==X_BINS and yCnt==Y_BINS, go to CLEAR. readHistogram deasserts that same transition cycle.
  - Timeout counter resets on any valid beat. When it reaches TIMEOUT_CYCLES: set error=1, go to CLEAR, and discard partial results (published outputs stay at previous values).
- CLEAR:
  - clearHistogram=1 until histogramCleared is sampled high. Then deassert and go to DONE.
  - histogramCleared already high on CLEAR entry: one cycle of clearHistogram, then DONE.
- DONE:
  - done=1 for exactly one cycle; go to IDLE.
  - If error=0, published result registers update at DONE entry, so they are valid while done=1. They hold until the next successful DONE.
  - objectFound=1 only if both axes had a qualifying bin. Otherwise objectFound=0 and xMin/xMax/yMin/yMax=0.
- start while busy is ignored and does not restart.
- Minimum latency from start to done is max(X_BINS, Y_BINS) beats + 3 cycles, assuming one beat per cycle and an immediate histogramCleared.
- Reset asserted mid-operation returns to IDLE immediately with all outputs 0, and drops readHistogram and clearHistogram in the same instant.

Test Plan:
- Basic: threshold=10. x bins all 0 except bins 50..60=20 and bin 55=200. y bins all 0 except 30..40=15 and bin 33=90. -> xPeakIndex=55, xPeakValue=200, xMin=50, xMax=60, yPeakIndex=33, yPeakValue=90, yMin=30, yMax=40, objectFound=1, done pulse width 1, error=0.
- Tie and empty: x bins 10 and 20 both =77, rest 0; y all 0; threshold=5. -> xPeakIndex=10, yPeakValue=0, yPeakIndex=0, objectFound=0, yMin=yMax=0.
- Interleave and excess: x at 1 beat/cycle, y every 3rd cycle, plus 5 extra xValid beats after bin 239. -> extras ignored, done after the 180th y beat + CLEAR, readHistogram low from the CLEAR cycle on.
- Timeout: stop y after 100 beats, TIMEOUT_CYCLES=1024. -> error=1 after 1024 idle cycles, clearHistogram asserted, done pulses, results unchanged from the previous run. Next start clears error.
- Clear handshake: histogramCleared delayed 7 cycles -> clearHistogram high exactly 7 cycles, done on the following cycle. A start pulse during CLEAR is ignored.
- Reset mid-READ at bin 120 -> all outputs 0 immediately. A fresh start afterwards produces correct results for a full stream.
